fib_acc: RTL and testbench

//  Downstream consumer of the fib engine: takes 32-bit Fibonacci results over a valid/ready handshake,

---
 rtl/fib_acc.sv | 122 ++++++++++++
 tb/tb_fib_acc.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_acc.sv
// fib_acc: accumulates groups of 32-bit Fibonacci results into a saturating sum behind valid/ready ports.
// Optional per-group maximum tracking is enabled by defining FIB_ACC_MAX_EN.
module fib_acc #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] len_in,
    input  logic [31:0]      res_in,
    input  logic             vld_in,
    output logic             rdy_in,
    output logic [ACC_W-1:0] sum_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf_out,
    output logic [31:0]      max_out,
    output logic             vld_out,
    input  logic             rdy_out
);

    // Handshakes: a word moves on a rising edge where valid and ready are both high; a
    // producer keeps valid and data steady until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W:0]   count;
    logic [CNT_W:0]   len;
    logic             ovf;
    logic             accept;
    logic             xfer;
    logic [CNT_W:0]   len_first;
    logic [CNT_W:0]   count_inc;
    logic [ACC_W:0]   sum_wide;

    assign accept    = vld_in & rdy_in;
    assign xfer      = vld_out & rdy_out;
    // A zero length field stands for a full 2^CNT_W group, hence the extra bit.
    assign len_first = (len_in == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len_in};
    assign count_inc = count + ONE;
    assign sum_wide  = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, res_in};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (len_first == ONE) ? HOLD : ACC;
            ACC:     if (accept && (count_inc == len)) state_nx = HOLD;
            HOLD:    if (xfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) state_nx = IDLE;
    end

    // rdy_in and vld_out are registered copies of the next state so both stay low in reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdy_in  <= 1'b0;
            vld_out <= 1'b0;
            acc     <= '0;
            count   <= '0;
            len     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            rdy_in  <= (state_nx != HOLD);
            vld_out <= (state_nx == HOLD);
            if (clr || ((state == HOLD) && xfer)) begin
                acc   <= '0;
                count <= '0;
                len   <= '0;
                ovf   <= 1'b0;
            end else if (accept && (state == IDLE)) begin
                acc   <= ACC_W'(res_in);
                count <= ONE;
                len   <= len_first;
                ovf   <= 1'b0;
            end else if (accept && (state == ACC)) begin
                count <= count_inc;
                if (sum_wide[ACC_W]) begin
                    acc <= '1;
                    ovf <= 1'b1;
                end else begin
                    acc <= sum_wide[ACC_W-1:0];
                end
            end
        end
    end

    assign sum_out = acc;
    assign cnt_out = count[CNT_W-1:0];
    assign ovf_out = ovf;

`ifdef FIB_ACC_MAX_EN
    logic [31:0] max_r;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            max_r <= '0;
        end else if (clr || ((state == HOLD) && xfer)) begin
            max_r <= '0;
        end else if (accept && (state == IDLE)) begin
            max_r <= res_in;
        end else if (accept && (state == ACC) && (res_in > max_r)) begin
            max_r <= res_in;
        end
    end

    assign max_out = max_r;
`else
    assign max_out = 32'h0;
`endif

endmodule

// File: tb/tb_fib_acc.sv
// tb_fib_acc: self-checking bench for fib_acc; a 48-bit and a 32-bit instance share one stimulus stream.
module tb_fib_acc;

    typedef struct packed {
        logic [47:0] s48;
        logic [31:0] s32;
        logic [7:0]  cnt;
        logic        o48;
        logic        o32;
        logic [31:0] mx;
    } out_t;

`ifdef FIB_ACC_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic        CLK;
    logic        rst_n;
    logic        clr;
    logic [7:0]  len_in;
    logic [31:0] res_in;
    logic        vld_in;
    logic        rdy_out;
    logic        rdy_in,   rdy_in32;
    logic [47:0] sum48;
    logic [31:0] sum32;
    logic [7:0]  cnt_out,  cnt32;
    logic        ovf48,    ovf32;
    logic [31:0] max_out,  max32;
    logic        vld_out,  vld_out32;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    out_t        got_q[$];
    out_t        exp_q[$];

    fib_acc #(.ACC_W(48), .CNT_W(8)) dut48 (
        .CLK(CLK), .rst_n(rst_n), .clr(clr), .len_in(len_in), .res_in(res_in),
        .vld_in(vld_in), .rdy_in(rdy_in), .sum_out(sum48), .cnt_out(cnt_out),
        .ovf_out(ovf48), .max_out(max_out), .vld_out(vld_out), .rdy_out(rdy_out)
    );

    fib_acc #(.ACC_W(32), .CNT_W(8)) dut32 (
        .CLK(CLK), .rst_n(rst_n), .clr(clr), .len_in(len_in), .res_in(res_in),
        .vld_in(vld_in), .rdy_in(rdy_in32), .sum_out(sum32), .cnt_out(cnt32),
        .ovf_out(ovf32), .max_out(max32), .vld_out(vld_out32), .rdy_out(rdy_out)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Record every output transfer (clr takes precedence and drops it).
    always @(negedge CLK) begin
        if (rst_n && vld_out && rdy_out && !clr)
            got_q.push_back(out_t'({sum48, sum32, cnt_out, ovf48, ovf32, max_out}));
    end

    // Reference: a group's result is its plain sum clamped to the sum width.
    function automatic out_t model_group(input logic [7:0] len_f, input logic [31:0] vals[$]);
        out_t            r;
        longint unsigned total;
        logic [31:0]     mx;
        total = 0;
        mx    = 0;
        foreach (vals[i]) begin
            total += longint'(vals[i]);
            if (vals[i] > mx) mx = vals[i];
        end
        r.o48 = (total > 64'h0000_FFFF_FFFF_FFFF);
        r.s48 = r.o48 ? 48'hFFFF_FFFF_FFFF : total[47:0];
        r.o32 = (total > 64'h0000_0000_FFFF_FFFF);
        r.s32 = r.o32 ? 32'hFFFF_FFFF : total[31:0];
        r.cnt = len_f;
        r.mx  = MAX_EN ? mx : 32'h0;
        return r;
    endfunction

    // driver tasks: all inputs change 1 time unit after a rising edge
    task automatic send_one(input logic [31:0] v, input int gap);
        int n;
        n      = 0;
        res_in = v;
        vld_in = 1'b1;
        while (1) begin
            @(negedge CLK);
            if (rdy_in) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: rdy_in=%0b after %0d cycles, required 1", rdy_in, n);
                break;
            end
        end
        @(posedge CLK);
        #1;
        vld_in = 1'b0;
        res_in = $urandom();
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // len_in is scrambled after the first accept: only that first sample may matter.
    task automatic send_group(input logic [7:0] len_f, input logic [31:0] vals[$], input int gap_max);
        len_in = len_f;
        foreach (vals[i]) begin
            send_one(vals[i], $urandom_range(0, gap_max));
            if (i == 0) len_in = 8'($urandom());
        end
    endtask

    task automatic wait_captures(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 2000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: got %0d transfers, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; len_in = 8'd0; res_in = 32'h0; vld_in = 1'b0; rdy_out = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({rdy_in, vld_out, ovf48, cnt_out} !== 11'h0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy=%0b vld=%0b ovf=%0b cnt=%0d, required all 0", rdy_in, vld_out, ovf48, cnt_out);
        end
        checks++;
        if ({sum48, sum32, max_out} !== 112'h0) begin
            errors++;
            $display("FAIL reset_data: sum48=%0h sum32=%0h max=%0h, required 0", sum48, sum32, max_out);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (rdy_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_early: rdy_in=%0b before first edge, required 0", rdy_in);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (rdy_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy_rise: rdy_in=%0b, required 1", rdy_in);
        end
    endtask

    task automatic test_basic();
        logic [31:0] v[$];
        got_q.delete();
        rdy_out = 1'b1;
        v = '{32'd8, 32'd13, 32'd21};
        send_group(8'd3, v, 0);
        checks++;
        if ({vld_out, rdy_in} !== 2'b10) begin
            errors++;
            $display("FAIL basic_latency: vld_out=%0b rdy_in=%0b, required 1 0", vld_out, rdy_in);
        end
        checks++;
        if ({sum48, cnt_out, ovf48} !== {48'd42, 8'd3, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: sum=%0d cnt=%0d ovf=%0b, required 42 3 0", sum48, cnt_out, ovf48);
        end
        checks++;
        if (max_out !== (MAX_EN ? 32'd21 : 32'd0)) begin
            errors++;
            $display("FAIL basic_max: max=%0d, required %0d", max_out, MAX_EN ? 21 : 0);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({vld_out, rdy_in, sum48} !== {2'b01, 48'd0} || got_q.size() != 1) begin
            errors++;
            $display("FAIL basic_pulse: vld_out=%0b rdy_in=%0b sum=%0d transfers=%0d, required 0 1 0 1",
                     vld_out, rdy_in, sum48, got_q.size());
        end
    endtask

    task automatic test_hold();
        logic [31:0] v[$];
        got_q.delete();
        rdy_out = 1'b0;
        v = '{32'd55};
        send_group(8'd1, v, 0);
        repeat (6) begin
            @(negedge CLK);
            checks++;
            if ({vld_out, rdy_in, sum48} !== {2'b10, 48'd55}) begin
                errors++;
                $display("FAIL hold_stable: vld_out=%0b rdy_in=%0b sum=%0d, required 1 0 55", vld_out, rdy_in, sum48);
            end
        end
        @(posedge CLK);
        #1;
        rdy_out = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (vld_out !== 1'b0 || got_q.size() != 1 || got_q[0].s48 !== 48'd55) begin
            errors++;
            $display("FAIL hold_release: vld_out=%0b transfers=%0d, required 0 and one transfer of 55", vld_out, got_q.size());
        end
    endtask

    task automatic test_saturate();
        logic [31:0] v[$];
        got_q.delete();
        rdy_out = 1'b1;
        v = '{32'hFFFF_FFF0, 32'h20};
        send_group(8'd2, v, 0);
        checks++;
        if ({sum32, ovf32, vld_out32} !== {32'hFFFF_FFFF, 2'b11}) begin
            errors++;
            $display("FAIL sat32: sum=%0h ovf=%0b vld=%0b, required ffffffff 1 1", sum32, ovf32, vld_out32);
        end
        checks++;
        if ({sum48, ovf48} !== {48'h1_0000_0010, 1'b0}) begin
            errors++;
            $display("FAIL sat48_wide: sum=%0h ovf=%0b, required 100000010 0", sum48, ovf48);
        end
        v = '{32'd5};
        send_group(8'd1, v, 0);
        checks++;
        if ({sum32, ovf32} !== {32'd5, 1'b0} || rdy_in32 !== 1'b0) begin
            errors++;
            $display("FAIL sat_next_group: sum32=%0h ovf32=%0b rdy32=%0b, required 5 0 0", sum32, ovf32, rdy_in32);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_len0();
        got_q.delete();
        rdy_out = 1'b1;
        len_in  = 8'd0;
        for (int i = 0; i < 255; i++) send_one(32'd1, 0);
        checks++;
        if ({vld_out, cnt_out} !== {1'b0, 8'd255}) begin
            errors++;
            $display("FAIL len0_early: vld_out=%0b cnt=%0d after 255 accepts, required 0 255", vld_out, cnt_out);
        end
        send_one(32'd1, 0);
        checks++;
        if ({vld_out, sum48, cnt_out} !== {1'b1, 48'd256, 8'd0}) begin
            errors++;
            $display("FAIL len0_done: vld_out=%0b sum=%0d cnt=%0d, required 1 256 0", vld_out, sum48, cnt_out);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_clr();
        logic [31:0] v[$];
        got_q.delete();
        rdy_out = 1'b1;
        len_in  = 8'd4;
        send_one(32'd3, 0);
        send_one(32'd4, 0);
        clr    = 1'b1;
        vld_in = 1'b1;
        res_in = 32'd100;
        @(posedge CLK);
        #1;
        clr    = 1'b0;
        vld_in = 1'b0;
        checks++;
        if ({vld_out, rdy_in, sum48, cnt_out} !== {2'b01, 48'd0, 8'd0}) begin
            errors++;
            $display("FAIL clr_abort: vld_out=%0b rdy_in=%0b sum=%0d cnt=%0d, required 0 1 0 0", vld_out, rdy_in, sum48, cnt_out);
        end
        v = '{32'd5, 32'd8};
        send_group(8'd2, v, 0);
        checks++;
        if ({vld_out, sum48, cnt_out} !== {1'b1, 48'd13, 8'd2}) begin
            errors++;
            $display("FAIL clr_next: vld_out=%0b sum=%0d cnt=%0d, required 1 13 2", vld_out, sum48, cnt_out);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL clr_transfers: %0d transfers, required 1", got_q.size());
        end
    endtask

    task automatic test_rst_hold();
        logic [31:0] v[$];
        got_q.delete();
        rdy_out = 1'b0;
        v = '{32'd77};
        send_group(8'd1, v, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vld_out, rdy_in, sum48} !== {2'b00, 48'd0}) begin
            errors++;
            $display("FAIL rst_hold: vld_out=%0b rdy_in=%0b sum=%0d, required 0 0 0", vld_out, rdy_in, sum48);
        end
        @(posedge CLK);
        #1;
        rst_n   = 1'b1;
        rdy_out = 1'b1;
        v = '{32'd1};
        send_group(8'd1, v, 0);
        checks++;
        if ({vld_out, sum48, cnt_out} !== {1'b1, 48'd1, 8'd1}) begin
            errors++;
            $display("FAIL rst_next: vld_out=%0b sum=%0d cnt=%0d, required 1 1 1", vld_out, sum48, cnt_out);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL rst_transfers: %0d transfers, required 1", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v[$];
        int          c0;
        got_q.delete();
        exp_q.delete();
        rdy_out = 1'b1;
        c0 = cyc;
        for (int g = 0; g < 4; g++) begin
            v = '{$urandom(), $urandom()};
            exp_q.push_back(model_group(8'd2, v));
            send_group(8'd2, v, 0);
        end
        checks++;
        if (cyc - c0 != 11) begin
            errors++;
            $display("FAIL b2b_throughput: %0d cycles for 4 groups of 2, required 11", cyc - c0);
        end
        wait_captures(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_group%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v[$];
        logic [7:0]  len_f;
        bit          done;
        got_q.delete();
        exp_q.delete();
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 25; g++) begin
                    len_f = 8'($urandom_range(1, 8));
                    v.delete();
                    for (int i = 0; i < int'(len_f); i++)
                        v.push_back(($urandom_range(0, 2) == 0) ? (32'hFFFF_0000 | $urandom()) : $urandom());
                    exp_q.push_back(model_group(len_f, v));
                    send_group(len_f, v, 2);
                end
                wait_captures(25);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge CLK);
                    #1;
                    rdy_out = 1'($urandom_range(0, 1));
                end
            end
        join
        rdy_out = 1'b1;
        for (int i = 0; i < 25 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_group%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_saturate();
        test_len0();
        test_clr();
        test_rst_hold();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
